flow_stat_acc: RTL and testbench

Per-flow packet and byte statistics accumulator with read-and-clear access, the next generation of the team's flow statistics counter. It sits on the receive path next to the packet parser, taking one packet-size event per cycle tagged with a flow number. It keeps a byte total and a packet count per flow in on-chip memory, and returns and clears one flow's totals per read strobe for the host/CSR side. Compared with the previous counter it adds:

- a post-reset memory init sweep,
- packet counting,
- a fully pipelined read-modify-write with defined same-flow collision semantics,
- optional saturation.

---
 rtl/flow_stat_acc_if.sv | 44 ++++
 rtl/flow_stat_acc.sv | 217 +++++++++++++++++++++
 tb/tb_flow_stat_acc.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/flow_stat_acc_if.sv
// -----------------------------------------------------------------------------
// flow_stat_acc_if
//
// Bundles the update, read-request and read-response signals of the per-flow
// statistics accumulator.
//   master : packet parser / host side (drives updates and read strobes)
//   slave  : the accumulator itself
//
// Signals
//   rx_flow_num_i  flow number of the update
//   pkt_size_i     packet size in bytes
//   pkt_size_en_i  update valid
//   rd_stb_i       read-and-clear request
//   rd_flow_num_i  flow number to read
//   rd_bytes_o     byte total of the flow read
//   rd_pkts_o      packet total of the flow read
//   rd_data_val_o  one-cycle qualifier for rd_bytes_o / rd_pkts_o
//   init_done_o    high once the post-reset memory sweep has completed
// -----------------------------------------------------------------------------
interface flow_stat_acc_if #(
  parameter int unsigned A_WIDTH = 10,
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned P_WIDTH = 24
);
  logic [A_WIDTH-1:0] rx_flow_num_i;
  logic [15:0]        pkt_size_i;
  logic               pkt_size_en_i;
  logic               rd_stb_i;
  logic [A_WIDTH-1:0] rd_flow_num_i;
  logic [D_WIDTH-1:0] rd_bytes_o;
  logic [P_WIDTH-1:0] rd_pkts_o;
  logic               rd_data_val_o;
  logic               init_done_o;

  modport master (
    output rx_flow_num_i, pkt_size_i, pkt_size_en_i, rd_stb_i, rd_flow_num_i,
    input  rd_bytes_o, rd_pkts_o, rd_data_val_o, init_done_o
  );

  modport slave (
    input  rx_flow_num_i, pkt_size_i, pkt_size_en_i, rd_stb_i, rd_flow_num_i,
    output rd_bytes_o, rd_pkts_o, rd_data_val_o, init_done_o
  );
endinterface

// File: rtl/flow_stat_acc.sv
// -----------------------------------------------------------------------------
// flow_stat_acc
//
// Per-flow packet and byte statistics accumulator with read-and-clear access.
// One update and one read are accepted per cycle with no back-pressure. Each
// flow entry holds {bytes, pkts}. After reset every entry is swept to zero
// (one per cycle) before any event is accepted.
//
// Pipeline (edge t samples the inputs):
//   edge t   : capture request, synchronous read of both addressed entries
//   t..t+1   : forward the write committed at edge t, compute new values
//   edge t+1 : write back update / clear, capture read result
//   edge t+2 : drive rd_bytes_o / rd_pkts_o / rd_data_val_o
// Within one cycle the read is ordered before the update, so a same-flow
// collision returns the old totals and leaves {pkt_size_i, 1}.
//
// Ports
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    flow_stat_acc_if.slave (update, read request, read response, init)
//
// Build option
//   FLOW_STAT_SAT_EN  defined: counters saturate at all-ones
//                     undefined: counters wrap
// -----------------------------------------------------------------------------
module flow_stat_acc #(
  parameter int unsigned A_WIDTH = 10,
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned P_WIDTH = 24
) (
  input  logic           clk_i,
  input  logic           rst_i,
  flow_stat_acc_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** A_WIDTH;

  typedef struct packed {
    logic [D_WIDTH-1:0] bytes;
    logic [P_WIDTH-1:0] pkts;
  } entry_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Init / run FSM
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] init_addr_q, init_addr_d;
  logic               init_wr_en;
  logic               run_en;

  // NOTE: sequential state is assigned with <= only so every register samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can infer a latch.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      ST_INIT: begin
        init_addr_d = init_addr_q + A_WIDTH'(1);
        if (init_addr_q == '1) state_d = ST_RUN;
      end
      ST_RUN: ;
    endcase
  end

  always_comb begin
    init_wr_en = (state_q == ST_INIT);
    run_en     = (state_q == ST_RUN);
  end

  // Events are only accepted once the sweep has finished.
  logic upd_acc, rd_acc;
  assign upd_acc = run_en & bus.pkt_size_en_i;
  assign rd_acc  = run_en & bus.rd_stb_i;

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic               s1_upd_vld_q, s1_rd_vld_q;
  logic [A_WIDTH-1:0] s1_upd_flow_q, s1_rd_flow_q;
  logic [15:0]        s1_upd_size_q;
  entry_t             s1_upd_ent_q, s1_rd_ent_q;

  // Copy of what was written to memory at the most recent edge; the
  // synchronous read issued at that same edge cannot see it yet.
  logic               wb_upd_vld_q, wb_rd_vld_q;
  logic [A_WIDTH-1:0] wb_upd_flow_q, wb_rd_flow_q;
  entry_t             wb_upd_ent_q;

  logic               s2_rd_vld_q;
  entry_t             s2_rd_ent_q;

  logic               rd_val_q;
  logic [D_WIDTH-1:0] rd_bytes_q;
  logic [P_WIDTH-1:0] rd_pkts_q;

  entry_t             rd_cur, upd_cur, upd_new;

  // ---------------------------------------------------------------------------
  // Flow memory
  // ---------------------------------------------------------------------------
  entry_t mem [DEPTH];

  // NOTE: the memory array has no reset; the post-reset sweep zeroes it, which
  // keeps it mappable onto RAM.
  always_ff @(posedge clk_i) begin
    s1_upd_ent_q <= mem[bus.rx_flow_num_i];
    s1_rd_ent_q  <= mem[bus.rd_flow_num_i];
    if (!rst_i) begin
      if (init_wr_en)   mem[init_addr_q]   <= '0;
      if (s1_rd_vld_q)  mem[s1_rd_flow_q]  <= '0;
      // Last assignment wins: on a same-flow collision the update overrides
      // the clear, matching read-before-update ordering.
      if (s1_upd_vld_q) mem[s1_upd_flow_q] <= upd_new;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding and accumulate
  // ---------------------------------------------------------------------------
  always_comb begin
    // The update write of the previous cycle takes priority: when it collided
    // with a clear it already holds the post-clear value.
    rd_cur = s1_rd_ent_q;
    if (wb_upd_vld_q && (wb_upd_flow_q == s1_rd_flow_q)) begin
      rd_cur = wb_upd_ent_q;
    end else if (wb_rd_vld_q && (wb_rd_flow_q == s1_rd_flow_q)) begin
      rd_cur = '0;
    end

    upd_cur = s1_upd_ent_q;
    if (wb_upd_vld_q && (wb_upd_flow_q == s1_upd_flow_q)) begin
      upd_cur = wb_upd_ent_q;
    end else if (wb_rd_vld_q && (wb_rd_flow_q == s1_upd_flow_q)) begin
      upd_cur = '0;
    end
    // Same-cycle read of this flow clears it before the packet is added.
    if (s1_rd_vld_q && (s1_rd_flow_q == s1_upd_flow_q)) upd_cur = '0;
  end

`ifdef FLOW_STAT_SAT_EN
  logic [D_WIDTH:0] byte_sum;

  always_comb begin
    upd_new       = upd_cur;
    byte_sum      = {1'b0, upd_cur.bytes} + (D_WIDTH + 1)'(s1_upd_size_q);
    upd_new.bytes = byte_sum[D_WIDTH] ? '1 : byte_sum[D_WIDTH-1:0];
    upd_new.pkts  = (&upd_cur.pkts) ? upd_cur.pkts : upd_cur.pkts + P_WIDTH'(1);
  end
`else
  always_comb begin
    upd_new       = upd_cur;
    upd_new.bytes = upd_cur.bytes + D_WIDTH'(s1_upd_size_q);
    upd_new.pkts  = upd_cur.pkts + P_WIDTH'(1);
  end
`endif

  // ---------------------------------------------------------------------------
  // Control registers (reset) and data registers (no reset needed)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_upd_vld_q <= 1'b0;
      s1_rd_vld_q  <= 1'b0;
      wb_upd_vld_q <= 1'b0;
      wb_rd_vld_q  <= 1'b0;
      s2_rd_vld_q  <= 1'b0;
      rd_val_q     <= 1'b0;
      rd_bytes_q   <= '0;
      rd_pkts_q    <= '0;
    end else begin
      s1_upd_vld_q <= upd_acc;
      s1_rd_vld_q  <= rd_acc;
      wb_upd_vld_q <= s1_upd_vld_q;
      wb_rd_vld_q  <= s1_rd_vld_q;
      s2_rd_vld_q  <= s1_rd_vld_q;
      rd_val_q     <= s2_rd_vld_q;
      // Output data holds its last value between read responses.
      if (s2_rd_vld_q) begin
        rd_bytes_q <= s2_rd_ent_q.bytes;
        rd_pkts_q  <= s2_rd_ent_q.pkts;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    s1_upd_flow_q <= bus.rx_flow_num_i;
    s1_upd_size_q <= bus.pkt_size_i;
    s1_rd_flow_q  <= bus.rd_flow_num_i;
    wb_upd_flow_q <= s1_upd_flow_q;
    wb_upd_ent_q  <= upd_new;
    wb_rd_flow_q  <= s1_rd_flow_q;
    s2_rd_ent_q   <= rd_cur;
  end

  assign bus.rd_bytes_o    = rd_bytes_q;
  assign bus.rd_pkts_o     = rd_pkts_q;
  assign bus.rd_data_val_o = rd_val_q;
  assign bus.init_done_o   = run_en;

endmodule

// File: tb/tb_flow_stat_acc.sv
// -----------------------------------------------------------------------------
// tb_flow_stat_acc
//
// Directed bench for flow_stat_acc. Instance dut_a uses the default widths;
// dut_b uses A_WIDTH=4, D_WIDTH=16, P_WIDTH=2 for the overflow cases.
// Read responses are collected by a monitor and matched in order against
// expectations recorded when each read is issued.
// -----------------------------------------------------------------------------
module tb_flow_stat_acc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flow_stat_acc_if #(.A_WIDTH(10), .D_WIDTH(32), .P_WIDTH(24)) if_a ();
  flow_stat_acc_if #(.A_WIDTH(4),  .D_WIDTH(16), .P_WIDTH(2))  if_b ();

  flow_stat_acc #(.A_WIDTH(10), .D_WIDTH(32), .P_WIDTH(24)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if_a.slave)
  );

  flow_stat_acc #(.A_WIDTH(4), .D_WIDTH(16), .P_WIDTH(2)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if_b.slave)
  );

  typedef struct {
    int     inst;
    int     ed;
    int     flow;
    longint b;
    longint p;
  } rd_t;

  rd_t    exp_q[$];
  rd_t    mon_q[$];
  int     edge_n = 0;
  int     total  = 0;
  int     bad    = 0;
  longint mdl_b[16];
  longint mdl_p[16];
  longint tot_b[16];
  longint tot_p[16];

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (if_a.rd_data_val_o)
      mon_q.push_back('{0, edge_n, 0, longint'(if_a.rd_bytes_o), longint'(if_a.rd_pkts_o)});
    if (if_b.rd_data_val_o)
      mon_q.push_back('{1, edge_n, 0, longint'(if_b.rd_bytes_o), longint'(if_b.rd_pkts_o)});
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle. inst bit0 drives dut_a, bit1 drives dut_b; the other
  // instance sees idle inputs.
  task automatic step(input int inst, input int ue, input int uf, input int us,
                      input int re, input int rf);
    if_a.pkt_size_en_i = (inst[0] && ue != 0);
    if_a.rx_flow_num_i = 10'(uf);
    if_a.pkt_size_i    = 16'(us);
    if_a.rd_stb_i      = (inst[0] && re != 0);
    if_a.rd_flow_num_i = 10'(rf);
    if_b.pkt_size_en_i = (inst[1] && ue != 0);
    if_b.rx_flow_num_i = 4'(uf);
    if_b.pkt_size_i    = 16'(us);
    if_b.rd_stb_i      = (inst[1] && re != 0);
    if_b.rd_flow_num_i = 4'(rf);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  // Record the response expected for a read issued in the step just taken.
  task automatic expect_rd(input int inst, input int flow, input longint b, input longint p);
    exp_q.push_back('{inst, edge_n, flow, b, p});
  endtask

  task automatic drain(input string tag);
    rd_t e, m;
    idle(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s_pulse_f%0d", tag, e.flow), longint'(mon_q.size() > 0), 1);
      if (mon_q.size() > 0) begin
        m = mon_q.pop_front();
        check($sformatf("%s_inst_f%0d", tag, e.flow), m.inst, e.inst);
        check($sformatf("%s_latency_f%0d", tag, e.flow), m.ed, e.ed + 2);
        check($sformatf("%s_bytes_f%0d", tag, e.flow), m.b, e.b);
        check($sformatf("%s_pkts_f%0d", tag, e.flow), m.p, e.p);
        if (e.inst == 0 && e.flow < 16) begin
          tot_b[e.flow] += m.b;
          tot_p[e.flow] += m.p;
        end
      end
    end
    check($sformatf("%s_extra_pulses", tag), mon_q.size(), 0);
    mon_q.delete();
  endtask

  // Release reset and count init_done_o low samples while stimulating dut_a
  // with updates and reads that must all be ignored.
  task automatic run_init(input string tag);
    int low_a, low_b;
    low_a = 0;
    low_b = 0;
    rst = 1'b0;
    if (!if_a.init_done_o) low_a++;
    if (!if_b.init_done_o) low_b++;
    for (int i = 0; i < 1100 && !if_a.init_done_o; i++) begin
      step(1, 1, 1023, 99, 1, 1023);
      if (!if_a.init_done_o) low_a++;
      if (!if_b.init_done_o) low_b++;
    end
    check({tag, "_low_cycles_a"}, low_a, 1024);
    check({tag, "_low_cycles_b"}, low_b, 16);
    check({tag, "_done_a"}, longint'(if_a.init_done_o), 1);
    check({tag, "_done_b"}, longint'(if_b.init_done_o), 1);
    check({tag, "_no_pulse"}, mon_q.size(), 0);
  endtask

  int re, rf;
  longint exp_b0, exp_p0, exp_b1, exp_p1;

  initial begin
    // ---- reset values ----
    rst = 1'b1;
    idle(3);
    check("rst_bytes", longint'(if_a.rd_bytes_o), 0);
    check("rst_pkts", longint'(if_a.rd_pkts_o), 0);
    check("rst_val", longint'(if_a.rd_data_val_o), 0);
    check("rst_done", longint'(if_a.init_done_o), 0);

    // ---- 1: init sweep, flow 1023 empty, INIT events ignored ----
    run_init("init");
    step(1, 0, 0, 0, 1, 1023);
    expect_rd(0, 1023, 0, 0);
    drain("t1");

    // ---- 2: back-to-back updates then immediate re-read ----
    step(1, 1, 3, 1, 0, 0);
    step(1, 1, 3, 2, 0, 0);
    step(1, 1, 3, 3, 0, 0);
    step(1, 0, 0, 0, 1, 3);
    expect_rd(0, 3, 6, 3);
    step(1, 0, 0, 0, 1, 3);
    expect_rd(0, 3, 0, 0);
    drain("t2");

    // ---- 3: same-cycle collision ----
    step(1, 1, 5, 10, 0, 0);
    step(1, 1, 5, 7, 1, 5);
    expect_rd(0, 5, 10, 1);
    idle(2);
    step(1, 0, 0, 0, 1, 5);
    expect_rd(0, 5, 7, 1);
    drain("t3");
    check("hold_bytes", longint'(if_a.rd_bytes_o), 7);
    check("hold_pkts", longint'(if_a.rd_pkts_o), 1);
    check("hold_val", longint'(if_a.rd_data_val_o), 0);

    // ---- 3b: zero-size packet, wide byte sum ----
    step(1, 1, 8, 0, 0, 0);
    step(1, 1, 7, 65535, 1, 8);
    expect_rd(0, 8, 0, 1);
    step(1, 1, 7, 65535, 0, 0);
    step(1, 0, 0, 0, 1, 7);
    expect_rd(0, 7, 131070, 2);
    drain("t3b");

    // ---- 4: interleaved flows against a reference model ----
    for (int f = 0; f < 16; f++) begin
      mdl_b[f] = 0; mdl_p[f] = 0; tot_b[f] = 0; tot_p[f] = 0;
    end
    for (int pass = 0; pass < 3; pass++) begin
      for (int f = 1; f <= 10; f++) begin
        re = 0;
        rf = 0;
        if (pass == 1 && f == 4) begin re = 1; rf = 3; end
        if (pass == 2 && f == 5) begin re = 1; rf = 5; end
        step(1, 1, f, f, re, rf);
        if (re != 0) begin
          expect_rd(0, rf, mdl_b[rf], mdl_p[rf]);
          mdl_b[rf] = 0;
          mdl_p[rf] = 0;
        end
        mdl_b[f] += f;
        mdl_p[f] += 1;
      end
    end
    for (int f = 1; f <= 10; f++) begin
      step(1, 0, 0, 0, 1, f);
      expect_rd(0, f, mdl_b[f], mdl_p[f]);
      mdl_b[f] = 0;
      mdl_p[f] = 0;
    end
    drain("t4");
    for (int f = 1; f <= 10; f++) begin
      check($sformatf("t4_total_bytes_f%0d", f), tot_b[f], 3 * f);
      check($sformatf("t4_total_pkts_f%0d", f), tot_p[f], 3);
    end

    // ---- 5: overflow on the narrow instance ----
`ifdef FLOW_STAT_SAT_EN
    exp_b0 = 65535; exp_p0 = 2; exp_b1 = 20; exp_p1 = 3;
`else
    exp_b0 = 14464; exp_p0 = 2; exp_b1 = 20; exp_p1 = 0;
`endif
    step(2, 1, 0, 40000, 0, 0);
    step(2, 1, 0, 40000, 0, 0);
    step(2, 0, 0, 0, 1, 0);
    expect_rd(1, 0, exp_b0, exp_p0);
    repeat (4) step(2, 1, 1, 5, 0, 0);
    step(2, 0, 0, 0, 1, 1);
    expect_rd(1, 1, exp_b1, exp_p1);
    drain("t5");

    // ---- 6: reset with a read in flight ----
    step(1, 1, 3, 9, 0, 0);
    step(1, 0, 0, 0, 1, 3);
    rst = 1'b1;
    idle(1);
    check("t6_rst_val", longint'(if_a.rd_data_val_o), 0);
    check("t6_rst_done", longint'(if_a.init_done_o), 0);
    run_init("reinit");
    step(1, 0, 0, 0, 1, 3);
    expect_rd(0, 3, 0, 0);
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
